axi_rd_data_buf: RTL and testbench
==================================

# axi_rd_data_buf

Parametrised buffer for the AXI read-data (R) channel, placed between an R-channel source (memory/interconnect side) and an R-channel sink (CNN datapath DMA side). It stores beats in a FIFO of configurable depth and carries a configurable user field. It supports cut-through and store-and-forward (whole-burst) release modes. It tracks occupancy and completed bursts, and flags error responses.

## Interface
- DATA_WIDTH, 32, rdata width
- ID_MAX_WIDTH, 12, rid width
- USER_WIDTH, 1, ruser width (>=1)
- DEPTH, 16, beats stored; power of 2, >=2
- PKT_MODE, 0, 0 = cut-through, 1 = store-and-forward on rlast
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- s_rid / s_rdata / s_rresp / s_rlast / s_ruser  in  ID_MAX_WIDTH / DATA_WIDTH / 2 / 1 / USER_WIDTH  upstream beat
- s_rvalid  in  1  upstream beat valid
- s_rready  out  1  buffer can accept a beat
- m_rid / m_rdata / m_rresp / m_rlast / m_ruser  out  same widths  downstream beat
- m_rvalid  out  1  downstream beat valid
- m_rready  in  1  downstream accepts
- level  out  $clog2(DEPTH+1)  beats stored
- bursts  out  $clog2(DEPTH+1)  complete bursts (rlast beats) stored
- err_clr  in  1  clears sticky flags
- resp_err  out  1  sticky: a popped beat had rresp[1]=1 (SLVERR/DECERR)
- oversize  out  1  sticky: PKT_MODE fallback taken

## Operation
- push = s_rvalid & s_rready; pop = m_rvalid & m_rready.
- s_rready = (level != DEPTH); full blocks push even if pop in same cycle.
- Beats leave in arrival order, all fields unchanged; no reordering by rid.
- level: +1 on push only, -1 on pop only, unchanged on both/neither.
- bursts: +1 on push with s_rlast, -1 on pop with m_rlast, net per cycle.
- Release rule (m_rvalid):
  - PKT_MODE=0: m_rvalid = (level != 0).
  - PKT_MODE=1: m_rvalid = (level != 0) & ((bursts != 0) | fallback).
- fallback (PKT_MODE=1 only): set when level==DEPTH and bursts==0. Cleared on pop of an m_rlast beat. While set, behaves as cut-through. oversize sets with it.
- resp_err sets on pop with m_rresp[1]. oversize sets as above. Both clear on err_clr. If set and clear occur in the same cycle, set wins.
- m_* payload is valid only while m_rvalid=1. It is held stable while m_rvalid & !m_rready (AXI rule).
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.

## Timing
- Reset (async assert, sync-released use by clk):
  - level=0, bursts=0, pointers=0
  - m_rvalid=0, s_rready=0 during reset, 1 from first clk edge after deassert
  - resp_err=0, oversize=0, fallback=0
  - m_* payload=0
- Reset mid-burst discards all stored beats; no partial burst survives.
- Latency, cut-through: beat pushed at edge N gives m_rvalid=1 after edge N (visible in cycle N+1). Zero-bubble throughput of 1 beat/cycle when m_rready held high.
- Latency, store-and-forward: first beat of a burst is visible the cycle after its rlast beat is pushed.
- s_rready depends only on registered level; there is no combinational path from m_rready to s_rready.
- m_rvalid and m_* are from registers or memory read with registered address. No combinational path from s_* to m_*.
- level/bursts are updated at the same edge as the push/pop they count.

## Structure
- Package axi_pkg: resp enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11).
- Package axi_pkg: function for the counter width, clog2(DEPTH+1).
- One sub-module, axi_rd_fifo_mem: DEPTH x (ID_MAX_WIDTH+DATA_WIDTH+2+1+USER_WIDTH) storage. It has one write port and one read port, with read data registered on the read-address path. It holds no reset on storage.
- Top level holds pointers, counters, release logic and sticky flags.

## Test plan
- Cut-through, DEPTH=16: push 4 beats rid=5, data 1..4, rlast on 4th, m_rready=1 -> m_rvalid from cycle after first push. Beats out in order 1..4, m_rlast on data 4, level back to 0.
- Backpressure/full, DEPTH=4: m_rready=0, s_rvalid=1 for 6 cycles -> 4 beats accepted, s_rready=0 with level=4. Then m_rready=1 -> s_rready returns after first pop, and there is no loss or duplication.
- PKT_MODE=1: push 3-beat burst, hold rlast until cycle 10 -> m_rvalid stays 0 until the cycle after the rlast push. bursts=1, then 0 after the last pop.
- PKT_MODE=1 oversize, DEPTH=4: 6-beat burst -> at level=4 with bursts=0, oversize=1 and draining starts. All 6 beats delivered in order, and fallback clears after the m_rlast pop.
- Errors: beat with rresp=2'b11 popped -> resp_err=1 next cycle. err_clr with a simultaneous SLVERR pop -> resp_err remains 1.
- Async reset asserted mid-burst with level=3 -> level, bursts, m_rvalid and flags read 0 immediately. After release, a fresh burst passes cleanly.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-channel types and sizing helpers for the R-channel buffer.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic resp_is_err(input resp_e resp);
    return (resp == SLVERR) || (resp == DECERR);
  endfunction

endpackage

// File: rtl/axi_rd_fifo_mem.sv
// Beat storage for the R-channel buffer: one write port, one read port driven
// by a registered read address. Storage contents are not reset.
module axi_rd_fifo_mem #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port; a slot is never written while it holds the head beat.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/axi_rd_data_buf.sv
// AXI R-channel buffer with cut-through or whole-burst release, occupancy and
// burst counters, and sticky error/oversize flags.
module axi_rd_data_buf
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ID_MAX_WIDTH = 12,
  parameter int USER_WIDTH   = 1,
  parameter int DEPTH        = 16,
  parameter int PKT_MODE     = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ID_MAX_WIDTH-1:0]       s_rid,
  input  logic [DATA_WIDTH-1:0]         s_rdata,
  input  logic [1:0]                    s_rresp,
  input  logic                          s_rlast,
  input  logic [USER_WIDTH-1:0]         s_ruser,
  input  logic                          s_rvalid,
  output logic                          s_rready,
  output logic [ID_MAX_WIDTH-1:0]       m_rid,
  output logic [DATA_WIDTH-1:0]         m_rdata,
  output logic [1:0]                    m_rresp,
  output logic                          m_rlast,
  output logic [USER_WIDTH-1:0]         m_ruser,
  output logic                          m_rvalid,
  input  logic                          m_rready,
  output logic [cnt_width(DEPTH)-1:0]   level,
  output logic [cnt_width(DEPTH)-1:0]   bursts,
  input  logic                          err_clr,
  output logic                          resp_err,
  output logic                          oversize
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = cnt_width(DEPTH);
  localparam int PW = ID_MAX_WIDTH + DATA_WIDTH + 2 + 1 + USER_WIDTH;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] CNT_ONE  = LW'(32'd1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);

  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [LW-1:0] level_r, bursts_r, level_nxt_s, bursts_nxt_s;
  logic          ready_en_r, fallback_r, resp_err_r, oversize_r;
  logic          push_s, pop_s, rvalid_s, fb_set_s;
  logic [PW-1:0] wr_data_s, rd_data_s;
  resp_e         pop_resp_s;

  assign push_s     = s_rvalid & s_rready;
  assign pop_s      = m_rvalid & m_rready;
  assign wr_data_s  = {s_rid, s_rdata, s_rresp, s_rlast, s_ruser};
  assign pop_resp_s = resp_e'(m_rresp);
  // An incomplete burst that fills the buffer could never be released whole.
  assign fb_set_s   = (PKT_MODE != 32'sd0) && (level_r == FULL_LVL) &&
                      (bursts_r == {LW{1'b0}});

  axi_rd_fifo_mem #(
    .WIDTH (PW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (wr_data_s),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  // Release rule: cut-through, or only once a whole burst (or fallback) is held.
  always_comb begin
    rvalid_s = 1'b0;
    if (level_r == {LW{1'b0}}) begin
      rvalid_s = 1'b0;
    end else if (PKT_MODE == 32'sd0) begin
      rvalid_s = 1'b1;
    end else begin
      rvalid_s = (bursts_r != {LW{1'b0}}) | fallback_r;
    end
  end

  assign s_rready = ready_en_r & (level_r != FULL_LVL);
  assign m_rvalid = rvalid_s;
  assign {m_rid, m_rdata, m_rresp, m_rlast, m_ruser} = rvalid_s ? rd_data_s : {PW{1'b0}};

  // Occupancy and burst counters move by the net of this cycle's push and pop.
  always_comb begin
    level_nxt_s  = level_r;
    bursts_nxt_s = bursts_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + CNT_ONE;
      2'b01:   level_nxt_s = level_r - CNT_ONE;
      default: level_nxt_s = level_r;
    endcase
    case ({push_s & s_rlast, pop_s & m_rlast})
      2'b10:   bursts_nxt_s = bursts_r + CNT_ONE;
      2'b01:   bursts_nxt_s = bursts_r - CNT_ONE;
      default: bursts_nxt_s = bursts_r;
    endcase
  end

  // Pointers, counters and the post-reset ready enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      bursts_r   <= {LW{1'b0}};
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      level_r    <= level_nxt_s;
      bursts_r   <= bursts_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Fallback and sticky flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fallback_r <= 1'b0;
      oversize_r <= 1'b0;
      resp_err_r <= 1'b0;
    end else begin
      if (fb_set_s) begin
        fallback_r <= 1'b1;
        oversize_r <= 1'b1;
      end else begin
        if (pop_s && m_rlast) begin
          fallback_r <= 1'b0;
        end
        if (err_clr) begin
          oversize_r <= 1'b0;
        end
      end
      if (pop_s && resp_is_err(pop_resp_s)) begin
        resp_err_r <= 1'b1;
      end else if (err_clr) begin
        resp_err_r <= 1'b0;
      end
    end
  end

  assign level    = level_r;
  assign bursts   = bursts_r;
  assign resp_err = resp_err_r;
  assign oversize = oversize_r;

endmodule

// File: tb/tb_axi_rd_data_buf.sv
// Self-checking bench: three buffer instances (16/cut-through, 4/cut-through,
// 4/store-and-forward) checked every cycle against a queue-based model.
module tb_axi_rd_data_buf;
  import axi_pkg::*;

  typedef struct packed {
    logic [11:0] id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } beat_t;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic  s_rvalid [NI];
  logic  m_rready [NI];
  logic  err_clr  [NI];
  beat_t s_beat   [NI];
  logic  s_rready_o [NI];
  logic  m_rvalid_o [NI];
  logic  resp_err_o [NI];
  logic  oversize_o [NI];
  beat_t m_beat_o   [NI];
  logic [4:0] level_o  [NI];
  logic [4:0] bursts_o [NI];

  int checks = 0;
  int errors = 0;

  beat_t mq    [NI][$];
  beat_t log_q [NI][$];
  logic  started [NI];
  logic  fb      [NI];
  logic  rerr    [NI];
  logic  ovs     [NI];
  logic  acc     [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DP  = (g == 0) ? 16 : 4;
    localparam int LWG = $clog2(DP + 1);
    logic [LWG-1:0] lvl, bst;
    logic [11:0] mid;
    logic [31:0] mdata;
    logic [1:0]  mresp;
    logic        mlast, muser;

    axi_rd_data_buf #(
      .DATA_WIDTH(32), .ID_MAX_WIDTH(12), .USER_WIDTH(1),
      .DEPTH(DP), .PKT_MODE((g == 2) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .s_rid(s_beat[g].id), .s_rdata(s_beat[g].data), .s_rresp(s_beat[g].resp),
      .s_rlast(s_beat[g].last), .s_ruser(s_beat[g].user),
      .s_rvalid(s_rvalid[g]), .s_rready(s_rready_o[g]),
      .m_rid(mid), .m_rdata(mdata), .m_rresp(mresp), .m_rlast(mlast), .m_ruser(muser),
      .m_rvalid(m_rvalid_o[g]), .m_rready(m_rready[g]),
      .level(lvl), .bursts(bst),
      .err_clr(err_clr[g]), .resp_err(resp_err_o[g]), .oversize(oversize_o[g])
    );

    assign m_beat_o[g] = {mid, mdata, mresp, mlast, muser};
    assign level_o[g]  = 5'(lvl);
    assign bursts_o[g] = 5'(bst);
  end

  function automatic int dep(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic logic pkt(input int k);
    return k == 2;
  endfunction

  function automatic beat_t mk(input logic [11:0] id, input logic [31:0] d,
                               input logic [1:0] r, input logic l);
    return {id, d, r, l, d[0]};
  endfunction

  function automatic int n_last(input int k);
    int c = 0;
    for (int i = 0; i < mq[k].size(); i++) begin
      if (mq[k][i].last) c++;
    end
    return c;
  endfunction

  function automatic logic exp_valid(input int k);
    if (mq[k].size() == 0) return 1'b0;
    if (!pkt(k)) return 1'b1;
    return (n_last(k) != 0) || fb[k];
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Model update at each edge, then compare every instance shortly after it.
  initial begin : model
    int n, nb;
    logic rdy, vld, do_push, do_pop, fset;
    forever begin
      @(posedge clk);
      for (int k = 0; k < NI; k++) begin
        if (!rst_n) begin
          mq[k].delete();
          started[k] = 1'b0;
          fb[k] = 1'b0;
          rerr[k] = 1'b0;
          ovs[k] = 1'b0;
        end else begin
          n = mq[k].size();
          nb = n_last(k);
          rdy = started[k] && (n != dep(k));
          vld = exp_valid(k);
          do_push = s_rvalid[k] && rdy;
          do_pop = vld && m_rready[k];
          fset = pkt(k) && (n == dep(k)) && (nb == 0);
          if (do_pop && mq[k][0].resp[1]) rerr[k] = 1'b1;
          else if (err_clr[k]) rerr[k] = 1'b0;
          if (fset) begin
            fb[k] = 1'b1;
            ovs[k] = 1'b1;
          end else begin
            if (do_pop && mq[k][0].last) fb[k] = 1'b0;
            if (err_clr[k]) ovs[k] = 1'b0;
          end
          if (do_pop) void'(mq[k].pop_front());
          if (do_push) mq[k].push_back(s_beat[k]);
          started[k] = 1'b1;
        end
      end
      #2;
      for (int k = 0; k < NI; k++) begin
        vld = exp_valid(k);
        chk("level", k, 64'(level_o[k]), 64'(mq[k].size()));
        chk("bursts", k, 64'(bursts_o[k]), 64'(n_last(k)));
        chk("s_rready", k, 64'(s_rready_o[k]), 64'(started[k] && (mq[k].size() != dep(k))));
        chk("m_rvalid", k, 64'(m_rvalid_o[k]), 64'(vld));
        chk("resp_err", k, 64'(resp_err_o[k]), 64'(rerr[k]));
        chk("oversize", k, 64'(oversize_o[k]), 64'(ovs[k]));
        if (vld) chk("m_beat", k, 64'(m_beat_o[k]), 64'(mq[k][0]));
      end
    end
  end

  // One cycle from a falling edge to the next, recording handshakes on the way.
  task automatic tick();
    #1;
    for (int k = 0; k < NI; k++) begin
      acc[k] = s_rvalid[k] && s_rready_o[k];
      if (m_rvalid_o[k] && m_rready[k]) log_q[k].push_back(m_beat_o[k]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int k, input logic [11:0] id, input logic [31:0] d,
                      input logic [1:0] r, input logic l);
    int n = 0;
    s_beat[k] = mk(id, d, r, l);
    s_rvalid[k] = 1'b1;
    acc[k] = 1'b0;
    while (!acc[k] && n < 40) begin
      tick();
      n++;
    end
    chk("send_accept", k, 64'(acc[k]), 64'd1);
    s_rvalid[k] = 1'b0;
  endtask

  task automatic chk_log(input int k, input int cnt, input logic [11:0] id,
                         input int base, input int last_idx);
    beat_t b;
    chk("log_count", k, 64'(log_q[k].size()), 64'(cnt));
    for (int i = 0; i < cnt; i++) begin
      b = (i < log_q[k].size()) ? log_q[k][i] : '0;
      chk("log_beat", k, 64'(b), 64'(mk(id, 32'(base + i), 2'b00, i == last_idx)));
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int idx;
    for (int k = 0; k < NI; k++) begin
      s_rvalid[k] = 1'b0;
      m_rready[k] = 1'b0;
      err_clr[k] = 1'b0;
      s_beat[k] = '0;
      acc[k] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rst_level", 0, 64'(level_o[0]), 64'd0);
    chk("rst_rready", 0, 64'(s_rready_o[0]), 64'd0);
    chk("rst_rvalid", 0, 64'(m_rvalid_o[0]), 64'd0);
    chk("rst_payload", 0, 64'(m_beat_o[0]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Cut-through, depth 16.
    m_rready[0] = 1'b1;
    log_q[0].delete();
    send(0, 12'd5, 32'd1, 2'b00, 1'b0);
    chk("ct_latency", 0, 64'(m_rvalid_o[0]), 64'd1);
    send(0, 12'd5, 32'd2, 2'b00, 1'b0);
    send(0, 12'd5, 32'd3, 2'b00, 1'b0);
    send(0, 12'd5, 32'd4, 2'b00, 1'b1);
    repeat (3) tick();
    chk_log(0, 4, 12'd5, 1, 3);
    chk("ct_level_end", 0, 64'(level_o[0]), 64'd0);

    // Backpressure and full, depth 4.
    log_q[1].delete();
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      s_beat[1] = mk(12'd7, 32'(16 + idx), 2'b00, idx == 5);
      s_rvalid[1] = 1'b1;
      tick();
      if (acc[1]) idx++;
    end
    chk("bp_accepted", 1, 64'(idx), 64'd4);
    chk("bp_level", 1, 64'(level_o[1]), 64'd4);
    chk("bp_rready", 1, 64'(s_rready_o[1]), 64'd0);
    m_rready[1] = 1'b1;
    tick();
    chk("bp_ready_back", 1, 64'(s_rready_o[1]), 64'd1);
    send(1, 12'd7, 32'd20, 2'b00, 1'b0);
    send(1, 12'd7, 32'd21, 2'b00, 1'b1);
    repeat (6) tick();
    chk_log(1, 6, 12'd7, 16, 5);

    // Store-and-forward: release only after the rlast beat.
    m_rready[2] = 1'b1;
    log_q[2].delete();
    send(2, 12'd3, 32'd100, 2'b00, 1'b0);
    send(2, 12'd3, 32'd101, 2'b00, 1'b0);
    repeat (5) begin
      tick();
      chk("pkt_hold", 2, 64'(m_rvalid_o[2]), 64'd0);
    end
    send(2, 12'd3, 32'd102, 2'b00, 1'b1);
    chk("pkt_release", 2, 64'(m_rvalid_o[2]), 64'd1);
    chk("pkt_bursts", 2, 64'(bursts_o[2]), 64'd1);
    repeat (5) tick();
    chk_log(2, 3, 12'd3, 100, 2);
    chk("pkt_bursts_end", 2, 64'(bursts_o[2]), 64'd0);

    // Oversize burst in store-and-forward, depth 4.
    log_q[2].delete();
    for (int i = 0; i < 4; i++) send(2, 12'd9, 32'(200 + i), 2'b00, 1'b0);
    chk("ovs_full_level", 2, 64'(level_o[2]), 64'd4);
    chk("ovs_hold", 2, 64'(m_rvalid_o[2]), 64'd0);
    send(2, 12'd9, 32'd204, 2'b00, 1'b0);
    send(2, 12'd9, 32'd205, 2'b00, 1'b1);
    repeat (8) tick();
    chk("ovs_flag", 2, 64'(oversize_o[2]), 64'd1);
    chk_log(2, 6, 12'd9, 200, 5);
    send(2, 12'd9, 32'd300, 2'b00, 1'b0);
    chk("fb_cleared", 2, 64'(m_rvalid_o[2]), 64'd0);
    send(2, 12'd9, 32'd301, 2'b00, 1'b1);
    repeat (4) tick();
    err_clr[2] = 1'b1;
    tick();
    err_clr[2] = 1'b0;
    chk("ovs_clr", 2, 64'(oversize_o[2]), 64'd0);

    // Error responses and set-wins-over-clear.
    send(0, 12'd1, 32'd499, 2'b01, 1'b1);
    tick();
    chk("rerr_exokay", 0, 64'(resp_err_o[0]), 64'd0);
    send(0, 12'd1, 32'd500, 2'b11, 1'b1);
    tick();
    chk("rerr_decerr", 0, 64'(resp_err_o[0]), 64'd1);
    err_clr[0] = 1'b1;
    tick();
    err_clr[0] = 1'b0;
    chk("rerr_clr", 0, 64'(resp_err_o[0]), 64'd0);
    m_rready[0] = 1'b0;
    send(0, 12'd1, 32'd501, 2'b10, 1'b1);
    m_rready[0] = 1'b1;
    err_clr[0] = 1'b1;
    tick();
    err_clr[0] = 1'b0;
    m_rready[0] = 1'b0;
    chk("rerr_set_wins", 0, 64'(resp_err_o[0]), 64'd1);

    // Asynchronous reset mid-burst, then a fresh burst.
    send(0, 12'd2, 32'd600, 2'b00, 1'b0);
    send(0, 12'd2, 32'd601, 2'b00, 1'b1);
    send(0, 12'd2, 32'd602, 2'b00, 1'b0);
    chk("pre_rst_level", 0, 64'(level_o[0]), 64'd3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_level", 0, 64'(level_o[0]), 64'd0);
    chk("arst_bursts", 0, 64'(bursts_o[0]), 64'd0);
    chk("arst_rvalid", 0, 64'(m_rvalid_o[0]), 64'd0);
    chk("arst_resp_err", 0, 64'(resp_err_o[0]), 64'd0);
    chk("arst_oversize", 0, 64'(oversize_o[0]), 64'd0);
    chk("arst_rready", 0, 64'(s_rready_o[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_rready[0] = 1'b1;
    log_q[0].delete();
    send(0, 12'd4, 32'd700, 2'b00, 1'b0);
    send(0, 12'd4, 32'd701, 2'b00, 1'b1);
    repeat (4) tick();
    chk_log(0, 2, 12'd4, 700, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
